// File: rtl/quad_step_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : quad_step_decoder
//  Purpose  : Quadrature (A/B) decoder. Synchronises and glitch-filters both
//             channels, then turns legal Gray-sequence transitions into a
//             one-cycle step pulse plus a held direction level. A transition
//             that flips both channels at once is reported as an error pulse.
//  Options  : QDEC_X4_EN defined   -> x4 decoding (step on every transition)
//             QDEC_X4_EN undefined -> x1 decoding (step only on entry to 00)
//  Revision : 1.0  initial release
// ============================================================================
module quad_step_decoder #(
   parameter int FILTER_LEN  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic clear_n,
   input  logic a_in,
   input  logic b_in,
   output logic step,
   output logic dir_up,
   output logic err,
   output logic ready
);

   localparam int C_FCNT_W = $clog2(FILTER_LEN + 1);
   localparam int C_SCNT_W = $clog2(SYNC_STAGES + 1);
   localparam logic [C_FCNT_W-1:0] C_FCNT_LAST = C_FCNT_W'(FILTER_LEN - 1);
   localparam logic [C_SCNT_W-1:0] C_SCNT_LAST = C_SCNT_W'(SYNC_STAGES - 1);

   localparam logic [1:0] S_SYNC  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_TRACK = 2'd2;

   // Channel vectors are ordered {A, B} throughout.
   logic [1:0]          w_raw;
   logic [1:0]          w_sync;
   logic [1:0]          w_filt;

   logic [1:0]          r_state;
   logic [1:0]          w_next;
   logic [C_SCNT_W-1:0] r_scnt;
   logic                w_load;
   logic                w_track;

   logic [1:0]          r_prev;
   logic [1:0]          w_delta;
   logic                w_up;
   logic                w_dn;
   logic                w_ill;
   logic                w_step_ev;
   logic                r_step;
   logic                r_err;
   logic                r_dir;

   // Position of a Gray code in the forward rotation 00->01->11->10.
   function automatic logic [1:0] gray_pos(input logic [1:0] g);
      return {g[1], g[1] ^ g[0]};
   endfunction

   assign w_raw = {a_in, b_in};

   generate
      for (genvar i = 0; i < 2; i++) begin : g_chan
         logic [SYNC_STAGES-1:0] r_sync;
         logic                   r_filt;
         logic [C_FCNT_W-1:0]    r_cnt;

         // Input synchroniser: shift the raw channel through SYNC_STAGES flops.
         always_ff @(posedge clk) begin
            if (!clear_n) begin
               r_sync <= '0;
            end else begin
               r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[i]};
            end
         end

         // Glitch filter: flip only after FILTER_LEN consecutive differing samples.
         always_ff @(posedge clk) begin
            if (!clear_n) begin
               r_filt <= 1'b0;
               r_cnt  <= '0;
            end else if (w_load) begin
               r_filt <= r_sync[SYNC_STAGES-1];
               r_cnt  <= '0;
            end else if (w_track) begin
               if (r_sync[SYNC_STAGES-1] == r_filt) begin
                  r_cnt <= '0;
               end else if (r_cnt == C_FCNT_LAST) begin
                  r_filt <= r_sync[SYNC_STAGES-1];
                  r_cnt  <= '0;
               end else begin
                  r_cnt <= r_cnt + C_FCNT_W'(1);
               end
            end
         end

         assign w_sync[i] = r_sync[SYNC_STAGES-1];
         assign w_filt[i] = r_filt;
      end
   endgenerate

   // Control FSM state register.
   always_ff @(posedge clk) begin
      if (!clear_n) begin
         r_state <= S_SYNC;
      end else begin
         r_state <= w_next;
      end
   end

   // Counts the cycles spent waiting for the synchronisers to fill.
   always_ff @(posedge clk) begin
      if (!clear_n) begin
         r_scnt <= '0;
      end else if ((r_state == S_SYNC) && (r_scnt != C_SCNT_LAST)) begin
         r_scnt <= r_scnt + C_SCNT_W'(1);
      end
   end

   // Control FSM next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_SYNC:  if (r_scnt == C_SCNT_LAST) w_next = S_LOAD;
         S_LOAD:  w_next = S_TRACK;
         S_TRACK: w_next = S_TRACK;
         default: w_next = S_SYNC;
      endcase
   end

   // Control FSM outputs.
   always_comb begin
      w_load  = 1'b0;
      w_track = 1'b0;
      ready   = 1'b0;
      case (r_state)
         S_LOAD:  w_load = 1'b1;
         S_TRACK: begin
            w_track = 1'b1;
            ready   = 1'b1;
         end
         default: ;
      endcase
   end

   // Transition classification: +1 is up, -1 is down, +2 is both bits flipping.
   always_comb begin
      w_delta = gray_pos(w_filt) - gray_pos(r_prev);
      w_up    = (w_delta == 2'd1);
      w_dn    = (w_delta == 2'd3);
      w_ill   = (w_delta == 2'd2);
`ifdef QDEC_X4_EN
      w_step_ev = w_up | w_dn;
`else
      w_step_ev = (w_up | w_dn) && (w_filt == 2'b00);
`endif
   end

   // Registered decoder outputs; prev tracks the filtered position while tracking.
   always_ff @(posedge clk) begin
      if (!clear_n) begin
         r_prev <= 2'b00;
         r_step <= 1'b0;
         r_err  <= 1'b0;
         r_dir  <= 1'b1;
      end else if (w_load) begin
         r_prev <= w_sync;
         r_step <= 1'b0;
         r_err  <= 1'b0;
      end else if (w_track) begin
         r_prev <= w_filt;
         r_step <= w_step_ev;
         r_err  <= w_ill;
         if (w_step_ev) begin
            r_dir <= w_up;
         end
      end else begin
         r_step <= 1'b0;
         r_err  <= 1'b0;
      end
   end

   assign step   = r_step;
   assign err    = r_err;
   assign dir_up = r_dir;

endmodule
`default_nettype wire
